// File: rtl/sample_msg_combiner_pkg.sv
// Shared definitions for the sample/message combiner and its matching splitter:
// length-field width, header-bit position and the FSM state encodings.
package sample_msg_combiner_pkg;

  // Width of the length field carried in a message header, just below the header bit.
  localparam int MSG_LENGTH_WIDTH = 16;

  // Write-side message parser states.
  typedef enum logic [1:0] {
    W_HDR,
    W_BODY,
    W_DISCARD
  } wr_state_t;

  // Read-side output sequencer states.
  typedef enum logic {
    R_IDLE,
    R_MSG
  } rd_state_t;

  // The top bit of a word marks a message header; data words keep it at 0.
  function automatic int hdr_bit_idx(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/sample_msg_combiner_buffer_fifo.sv
// Synchronous show-ahead FIFO. A push while full is ignored even when a pop
// happens on the same edge; a pop while empty is ignored. Also reports the
// number of free slots so a writer can reserve room for a whole message.
module buffer_fifo #(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [LOG_DEPTH:0]   free
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign free    = (LOG_DEPTH+1)'(DEPTH) - count;
  assign rd_data = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; pointers and count define validity, and
  // leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      count <= count + (LOG_DEPTH+1)'(do_push) - (LOG_DEPTH+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sample_msg_combiner.sv
// Merges a sample stream and a message stream into one word stream. Messages
// are buffered until complete, then emitted header-first with no samples in
// between; messages take priority over samples. Any dropped word sets a
// sticky error flag.
module sample_msg_combiner
  import sample_msg_combiner_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SAMPLE_BUF_LOG = 4,
  parameter int MSG_BUF_LOG    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_samples,
  input  logic             in_samples_nd,
  input  logic [WIDTH-1:0] in_msg,
  input  logic             in_msg_nd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nd,
  output logic             error
);

  localparam int HDR_BIT = hdr_bit_idx(WIDTH);
  localparam int LW      = MSG_LENGTH_WIDTH;
  localparam int LW1     = MSG_LENGTH_WIDTH + 1;
  localparam int MCW     = MSG_BUF_LOG + 1;

  function automatic logic [LW-1:0] msg_len(input logic [WIDTH-1:0] w);
    return w[HDR_BIT-1 -: LW];
  endfunction

  // Sample FIFO
  logic                  s_push, s_pop, s_full, s_empty;
  logic [WIDTH-1:0]      s_rd_data;
  logic [SAMPLE_BUF_LOG:0] s_free;

  // Message FIFO
  logic                  m_push, m_pop, m_full, m_empty;
  logic [WIDTH-1:0]      m_rd_data;
  logic [MSG_BUF_LOG:0]  m_free;

  // Write-side parser
  wr_state_t             w_state, w_state_next;
  logic [LW-1:0]         rem_w, rem_w_next;
  logic [LW-1:0]         in_len;
  logic                  in_is_hdr;
  logic                  msg_fits;
  logic                  msg_done;
  logic                  err_m;
  logic                  err_s;

  // Complete-message count shared by both sides
  logic [MCW-1:0]        msg_cnt;
  logic                  hdr_pop;

  // Read-side sequencer
  rd_state_t             r_state, r_state_next;
  logic [LW-1:0]         rem_r, rem_r_next;
  logic [LW-1:0]         head_len;
  logic [WIDTH-1:0]      out_data_next;
  logic                  out_nd_next;

  // Sample-side free count and message-side full/empty flags have no consumer here.
  logic                  unused_flags;
  assign unused_flags = ^{s_free, m_full, m_empty};

  buffer_fifo #(.WIDTH(WIDTH), .LOG_DEPTH(SAMPLE_BUF_LOG)) u_sample_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s_push),
    .wr_data (in_samples),
    .pop     (s_pop),
    .rd_data (s_rd_data),
    .full    (s_full),
    .empty   (s_empty),
    .free    (s_free)
  );

  buffer_fifo #(.WIDTH(WIDTH), .LOG_DEPTH(MSG_BUF_LOG)) u_msg_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (m_push),
    .wr_data (in_msg),
    .pop     (m_pop),
    .rd_data (m_rd_data),
    .full    (m_full),
    .empty   (m_empty),
    .free    (m_free)
  );

  // Samples: flagged words and words arriving while full are dropped.
  assign s_push = in_samples_nd && !in_samples[HDR_BIT];
  assign err_s  = in_samples_nd && (in_samples[HDR_BIT] || s_full);

  assign in_len    = msg_len(in_msg);
  assign in_is_hdr = in_msg[HDR_BIT];
  // A header is only admitted when the whole message (header + L words) fits.
  assign msg_fits  = LW1'(m_free) >= ({1'b0, in_len} + LW1'(1));
  assign head_len  = msg_len(m_rd_data);

  // Message parser: admit whole messages, discard oversize ones, flag protocol errors.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = w_state;
    rem_w_next   = rem_w;
    m_push       = 1'b0;
    msg_done     = 1'b0;
    err_m        = 1'b0;
    if (in_msg_nd) begin
      case (w_state)
        W_HDR: begin
          if (!in_is_hdr) begin
            err_m = 1'b1;
          end else if (msg_fits) begin
            m_push = 1'b1;
            if (in_len == '0) begin
              msg_done = 1'b1;
            end else begin
              rem_w_next   = in_len;
              w_state_next = W_BODY;
            end
          end else begin
            err_m = 1'b1;
            if (in_len != '0) begin
              rem_w_next   = in_len;
              w_state_next = W_DISCARD;
            end
          end
        end
        W_BODY: begin
          if (in_is_hdr) begin
            err_m = 1'b1;
          end else begin
            m_push     = 1'b1;
            rem_w_next = rem_w - LW'(1);
            if (rem_w == LW'(1)) begin
              msg_done     = 1'b1;
              w_state_next = W_HDR;
            end
          end
        end
        W_DISCARD: begin
          if (in_is_hdr) begin
            err_m = 1'b1;
          end else begin
            rem_w_next = rem_w - LW'(1);
            if (rem_w == LW'(1)) w_state_next = W_HDR;
          end
        end
        default: w_state_next = W_HDR;
      endcase
    end
  end

  // Parser state, complete-message count and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_HDR;
      rem_w   <= '0;
      msg_cnt <= '0;
      error   <= 1'b0;
    end else begin
      w_state <= w_state_next;
      rem_w   <= rem_w_next;
      msg_cnt <= msg_cnt + MCW'(msg_done) - MCW'(hdr_pop);
      error   <= error | err_s | err_m;
    end
  end

  // Read sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      rem_r   <= '0;
    end else begin
      r_state <= r_state_next;
      rem_r   <= rem_r_next;
    end
  end

  // Read sequencer next state: stay in MSG until the last content word goes out.
  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (msg_cnt != '0 && head_len != '0) r_state_next = R_MSG;
      R_MSG:   if (rem_r == LW'(1)) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read sequencer outputs: pick one word per cycle, complete messages first.
  always_comb begin
    m_pop         = 1'b0;
    s_pop         = 1'b0;
    hdr_pop       = 1'b0;
    rem_r_next    = rem_r;
    out_data_next = '0;
    out_nd_next   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (msg_cnt != '0) begin
          m_pop         = 1'b1;
          hdr_pop       = 1'b1;
          rem_r_next    = head_len;
          out_data_next = m_rd_data;
          out_nd_next   = 1'b1;
        end else if (!s_empty) begin
          s_pop         = 1'b1;
          out_data_next = s_rd_data;
          out_nd_next   = 1'b1;
        end
      end
      R_MSG: begin
        m_pop         = 1'b1;
        rem_r_next    = rem_r - LW'(1);
        out_data_next = m_rd_data;
        out_nd_next   = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_nd   <= 1'b0;
    end else begin
      out_data <= out_data_next;
      out_nd   <= out_nd_next;
    end
  end

endmodule

// File: tb/tb_sample_msg_combiner.sv
// Directed bench for sample_msg_combiner: latency, ordering, priority,
// overflow, protocol errors and mid-message reset.
module tb_sample_msg_combiner;

  logic        clk;
  logic        rst;
  logic [31:0] in_samples;
  logic        in_samples_nd;
  logic [31:0] in_msg;
  logic        in_msg_nd;
  logic [31:0] out_data;
  logic        out_nd;
  logic        error;

  int tests = 0;
  int fails = 0;

  logic [31:0] outq[$];

  sample_msg_combiner #(.WIDTH(32), .SAMPLE_BUF_LOG(4), .MSG_BUF_LOG(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_samples    (in_samples),
    .in_samples_nd (in_samples_nd),
    .in_msg        (in_msg),
    .in_msg_nd     (in_msg_nd),
    .out_data      (out_data),
    .out_nd        (out_nd),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every emitted word away from the active edge.
  always @(negedge clk) begin
    if (!rst && out_nd) outq.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] mk_hdr(input int len);
    logic [15:0] l16;
    l16 = 16'(len);
    return {1'b1, l16, 15'h0};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_samples_nd = 1'b0;
    in_msg_nd = 1'b0;
    steps(2);
    rst = 1'b0;
    step();
    outq.delete();
  endtask

  logic [31:0] exp_c[12];
  logic [31:0] samp_rx[$];
  logic [31:0] msg_rx[$];

  initial begin
    rst = 1'b1;
    in_samples = '0;
    in_samples_nd = 1'b0;
    in_msg = '0;
    in_msg_nd = 1'b0;
    #1;
    check("reset_out_nd", out_nd, 0);
    check("reset_out_data", out_data, 0);
    check("reset_error", error, 0);
    steps(3);
    rst = 1'b0;
    step();

    // Samples only: latency and ordering.
    outq.delete();
    in_samples = 32'h1; in_samples_nd = 1'b1; step();
    check("smp_lat_k", out_nd, 0);
    in_samples = 32'h2; step();
    check("smp_lat_k1_nd", out_nd, 1);
    check("smp_w1", out_data, 32'h1);
    in_samples = 32'h3; step();
    check("smp_w2", out_data, 32'h2);
    in_samples_nd = 1'b0; step();
    check("smp_w3", out_data, 32'h3);
    step();
    check("smp_idle", out_nd, 0);
    check("smp_err", error, 0);

    // Message only, with idle gaps between words.
    in_msg = mk_hdr(2); in_msg_nd = 1'b1; step();
    in_msg_nd = 1'b0; steps(2);
    check("msg_wait_nd", out_nd, 0);
    in_msg = 32'hA; in_msg_nd = 1'b1; step();
    in_msg_nd = 1'b0; step();
    in_msg = 32'hB; in_msg_nd = 1'b1; step();
    in_msg_nd = 1'b0;
    check("msg_last_k", out_nd, 0);
    step();
    check("msg_hdr_nd", out_nd, 1);
    check("msg_hdr", out_data, mk_hdr(2));
    step();
    check("msg_c0", out_data, 32'hA);
    step();
    check("msg_c1", out_data, 32'hB);
    check("msg_c1_nd", out_nd, 1);
    step();
    check("msg_idle", out_nd, 0);

    // L=0 header and a sample in the same cycle: header wins.
    in_msg = mk_hdr(0); in_msg_nd = 1'b1;
    in_samples = 32'h55; in_samples_nd = 1'b1;
    step();
    in_msg_nd = 1'b0; in_samples_nd = 1'b0;
    step();
    check("l0_hdr", out_data, mk_hdr(0));
    check("l0_hdr_nd", out_nd, 1);
    step();
    check("l0_smp", out_data, 32'h55);
    step();
    check("l0_idle", out_nd, 0);
    check("l0_err", error, 0);

    // Interleave: samples every cycle while an L=3 message trickles in.
    outq.delete();
    for (int c = 0; c < 8; c++) begin
      in_samples = 32'h100 + 32'(c);
      in_samples_nd = 1'b1;
      in_msg_nd = 1'b1;
      case (c)
        0: in_msg = mk_hdr(3);
        2: in_msg = 32'hC1;
        4: in_msg = 32'hC2;
        5: in_msg = 32'hC3;
        default: in_msg_nd = 1'b0;
      endcase
      step();
    end
    in_samples_nd = 1'b0; in_msg_nd = 1'b0;
    steps(8);
    exp_c = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, mk_hdr(3),
              32'hC1, 32'hC2, 32'hC3, 32'h105, 32'h106, 32'h107};
    check("ilv_count", 32'(outq.size()), 32'd12);
    for (int i = 0; i < 12; i++) check($sformatf("ilv_w%0d", i), outq[i], exp_c[i]);
    // Split the merged stream back into its two sources.
    samp_rx.delete(); msg_rx.delete();
    for (int i = 0; i < outq.size(); i++) begin
      if (outq[i][31]) begin
        msg_rx.push_back(outq[i]);
        for (int j = 0; j < int'(outq[i][30:15]); j++) msg_rx.push_back(outq[i+1+j]);
        i += int'(outq[i][30:15]);
      end else begin
        samp_rx.push_back(outq[i]);
      end
    end
    check("split_nsamp", 32'(samp_rx.size()), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("split_s%0d", i), samp_rx[i], 32'h100 + 32'(i));
    check("split_nmsg", 32'(msg_rx.size()), 32'd4);
    check("split_m3", msg_rx[3], 32'hC3);
    check("ilv_err", error, 0);

    // Sample overflow while the reader is busy with a 40-word message.
    outq.delete();
    for (int c = 0; c <= 40; c++) begin
      in_msg = (c == 0) ? mk_hdr(40) : 32'h300 + 32'(c);
      in_msg_nd = 1'b1;
      step();
    end
    in_msg_nd = 1'b0;
    for (int j = 0; j < 17; j++) begin
      in_samples = 32'h200 + 32'(j);
      in_samples_nd = 1'b1;
      step();
      if (j == 15) check("sovf_err_before", error, 0);
    end
    in_samples_nd = 1'b0;
    check("sovf_err_after", error, 1);
    steps(60);
    check("sovf_count", 32'(outq.size()), 32'd57);
    check("sovf_hdr", outq[0], mk_hdr(40));
    check("sovf_first_smp", outq[41], 32'h200);
    check("sovf_last_smp", outq[56], 32'h20F);

    // Oversize message discarded; following message still emitted.
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      in_msg = (c == 0) ? mk_hdr(10) : 32'h400 + 32'(c);
      in_msg_nd = 1'b1;
      step();
    end
    check("movf_err_before", error, 0);
    in_msg = mk_hdr(63); step();
    check("movf_err_after", error, 1);
    for (int c = 1; c <= 63; c++) begin
      in_msg = 32'h500 + 32'(c);
      step();
    end
    in_msg = mk_hdr(1); step();
    in_msg = 32'h77; step();
    in_msg_nd = 1'b0;
    steps(6);
    check("movf_count", 32'(outq.size()), 32'd13);
    check("movf_m1_hdr", outq[0], mk_hdr(10));
    check("movf_m1_last", outq[10], 32'h40A);
    check("movf_m2_hdr", outq[11], mk_hdr(1));
    check("movf_m2_c0", outq[12], 32'h77);

    // Content word while expecting a header.
    do_reset();
    in_msg = 32'h12; in_msg_nd = 1'b1; step();
    in_msg_nd = 1'b0; steps(3);
    check("hdr_content_err", error, 1);
    check("hdr_content_out", 32'(outq.size()), 32'd0);

    // Sample with the header bit set.
    do_reset();
    in_samples = 32'h8000_0001; in_samples_nd = 1'b1; step();
    in_samples_nd = 1'b0; steps(3);
    check("bad_smp_err", error, 1);
    check("bad_smp_out", 32'(outq.size()), 32'd0);

    // Reset in the middle of a message.
    do_reset();
    in_samples = 32'h8000_0002; in_samples_nd = 1'b1; step();
    in_samples = 32'h11; in_msg = mk_hdr(3); in_msg_nd = 1'b1; step();
    in_samples = 32'h12; in_msg = 32'hD1; step();
    in_samples_nd = 1'b0; in_msg_nd = 1'b0;
    check("mid_pre_nd", out_nd, 1);
    check("mid_pre_err", error, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_nd", out_nd, 0);
    check("mid_rst_err", error, 0);
    check("mid_rst_data", out_data, 0);
    steps(2);
    rst = 1'b0;
    outq.delete();
    steps(10);
    check("mid_no_stale", 32'(outq.size()), 32'd0);
    in_msg = mk_hdr(1); in_msg_nd = 1'b1; step();
    in_msg = 32'hE1; step();
    in_msg_nd = 1'b0;
    steps(4);
    check("mid_new_count", 32'(outq.size()), 32'd2);
    check("mid_new_hdr", outq[0], mk_hdr(1));
    check("mid_new_c0", outq[1], 32'hE1);
    check("mid_new_err", error, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
